// File: rtl/instr_fetch_if.sv
// instr_fetch_if: host-side and decode-side signal bundle for instr_fetch_queue
// Ports (slave = queue side):
//   host_word/host_valid in, host_ready out  : 32-bit half-word transfer from host
//   flush, stall in                          : synchronous clear, downstream hold
//   instruction, issue_valid out             : registered issued instruction
//   q_count, q_full, q_empty out             : registered FIFO occupancy and flags
interface instr_fetch_if #(parameter int AW = 3);
  logic [31:0] host_word;
  logic        host_valid;
  logic        host_ready;
  logic        flush;
  logic        stall;
  logic [63:0] instruction;
  logic        issue_valid;
  logic [AW:0] q_count;
  logic        q_full;
  logic        q_empty;
  modport master (
    output host_word, host_valid, flush, stall,
    input  host_ready, instruction, issue_valid, q_count, q_full, q_empty
  );
  modport slave (
    input  host_word, host_valid, flush, stall,
    output host_ready, instruction, issue_valid, q_count, q_full, q_empty
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: pairs 32-bit host words into 64-bit instructions, queues and issues them
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_fetch_if.slave (host handshake, flush/stall, issue outputs, occupancy)
module instr_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.slave bus
);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [31:0]   hold_q, hold_d;
  logic [63:0]   instr_q, instr_d;
  logic          iv_q, iv_d;
  logic          full, empty, acc, push, pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  // Only the pairing word needs FIFO space; a same-cycle pop does not help.
  assign bus.host_ready = ~half_q | ~full;
  // Words transferred during a flush are discarded.
  assign acc  = bus.host_valid & bus.host_ready & ~bus.flush;
  assign push = acc & half_q;
  assign pop  = ~bus.stall & ~empty & ~bus.flush;
  always_comb begin
    wr_d    = bus.flush ? '0 : wr_q + AW'(push);
    rd_d    = bus.flush ? '0 : rd_q + AW'(pop);
    cnt_d   = bus.flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    half_d  = bus.flush ? 1'b0 : (acc ? ~half_q : half_q);
    hold_d  = (acc & ~half_q) ? bus.host_word : hold_q;
    instr_d = pop ? mem_q[rd_q] : '0;
    iv_d    = pop;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {hold_q, bus.host_word};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      hold_q  <= '0;
      instr_q <= '0;
      iv_q    <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
    end
  assign bus.instruction = instr_q;
  assign bus.issue_valid = iv_q;
  assign bus.q_count     = cnt_q;
  assign bus.q_full      = full;
  assign bus.q_empty     = empty;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized and directed scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  instr_fetch_if #(.AW(AW)) bus();
  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  int maxc   = 0;
  logic [63:0] mq[$];
  logic [63:0] exp_q[$];
  bit          m_half = 0;
  logic [31:0] m_hold = '0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic bit m_ready();
    return !m_half || mq.size() < DEPTH;
  endfunction
  // Drive one cycle of stimulus and advance the reference model across the coming edge.
  task automatic step(input bit v, input logic [31:0] w, input bit s, input bit f);
    bit rdy, pp;
    @(negedge clk);
    bus.host_valid = v;
    bus.host_word  = w;
    bus.stall      = s;
    bus.flush      = f;
    rdy = m_ready();
    pp  = !s && mq.size() > 0 && !f;
    if (f) begin
      mq.delete();
      m_half = 0;
    end else begin
      if (pp) exp_q.push_back(mq.pop_front());
      if (v && rdy) begin
        if (m_half) begin
          mq.push_back({m_hold, w});
          m_half = 0;
        end else begin
          m_hold = w;
          m_half = 1;
        end
      end
    end
  endtask
  task automatic reset_checks();
    chk("rst_instruction", bus.instruction, 0);
    chk("rst_issue_valid", {63'b0, bus.issue_valid}, 0);
    chk("rst_q_count", 64'(bus.q_count), 0);
    chk("rst_q_empty", {63'b0, bus.q_empty}, 1);
    chk("rst_host_ready", {63'b0, bus.host_ready}, 1);
  endtask
  // Monitor: compares DUT outputs against the scoreboard just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (bus.issue_valid) begin
        if (exp_q.size() == 0) chk("spurious_issue", {63'b0, bus.issue_valid}, 0);
        else chk("issue_data", bus.instruction, exp_q.pop_front());
      end else begin
        if (exp_q.size() != 0) begin
          chk("missing_issue", {63'b0, bus.issue_valid}, 1);
          void'(exp_q.pop_front());
        end
        chk("idle_zero", bus.instruction, 0);
      end
      chk("q_count", 64'(bus.q_count), 64'(mq.size()));
      chk("q_full", {63'b0, bus.q_full}, {63'b0, mq.size() == DEPTH});
      chk("q_empty", {63'b0, bus.q_empty}, {63'b0, mq.size() == 0});
      chk("host_ready", {63'b0, bus.host_ready}, {63'b0, m_ready()});
      if (int'(bus.q_count) > maxc) maxc = int'(bus.q_count);
    end
  end
  // Overflow/underflow guard on the queue's internal push/pop strobes.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      a_no_overflow: assert (!(dut.push && bus.q_full)) else begin
        errors++;
        $display("FAIL push_while_full at %0t", $time);
      end
      a_no_underflow: assert (!(dut.pop && bus.q_empty)) else begin
        errors++;
        $display("FAIL pop_while_empty at %0t", $time);
      end
    end
  end
  initial begin
    bus.host_valid = 0;
    bus.host_word  = '0;
    bus.stall      = 0;
    bus.flush      = 0;
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    rst = 0;
    // Single instruction and its latency
    step(1, 32'h0800_1000, 0, 0);
    step(1, 32'h0000_0000, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("single_instr", bus.instruction, 64'h0800_1000_0000_0000);
    chk("single_valid", {63'b0, bus.issue_valid}, 1);
    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("single_once", {63'b0, bus.issue_valid}, 0);
    // Fill under stall, then hold the pairing word while full
    for (int i = 0; i < 2 * DEPTH; i++) step(1, 32'h1000_0000 + i, 1, 0);
    @(posedge clk);
    #2;
    chk("fill_full", {63'b0, bus.q_full}, 1);
    step(1, 32'hA000_0001, 1, 0);
    step(1, 32'hA000_0002, 1, 0);
    step(1, 32'hA000_0002, 1, 0);
    @(posedge clk);
    #2;
    chk("fill_hold_ready", {63'b0, bus.host_ready}, 0);
    for (int i = 0; i < 4 && m_half; i++) step(1, 32'hA000_0002, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
    // Stall toggling mid-stream
    for (int i = 0; i < 6; i++) step(1, 32'h2000_0000 + i, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // Flush with a half word pending and a word in flight
    for (int i = 0; i < 11; i++) step(1, 32'h3000_0000 + i, 1, 0);
    step(1, 32'h3BAD_BAD0, 0, 1);
    @(posedge clk);
    #2;
    chk("flush_count", 64'(bus.q_count), 0);
    step(1, 32'h3100_0001, 0, 0);
    step(1, 32'h3100_0002, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    // Continuous push/pop across pointer wrap
    maxc = 0;
    for (int i = 0; i < 6 * DEPTH; i++) step(1, 32'h4000_0000 + i, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("wrap_maxcnt", 64'(maxc > 1), 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0);
    // Asynchronous reset mid-operation
    for (int i = 0; i < 7; i++) step(1, 32'h5000_0000 + i, 1, 0);
    @(posedge clk);
    #3;
    bus.host_valid = 0;
    bus.stall      = 0;
    rst = 1;
    #1;
    reset_checks();
    mq.delete();
    exp_q.delete();
    m_half = 0;
    @(negedge clk);
    rst = 0;
    step(1, 32'h6000_0001, 0, 0);
    step(1, 32'h6000_0002, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
